// File: rtl/calc_engine.sv
// calc_engine: keypad calculator (add/sub/mul/div/clear), edge-started.
// Ports: clk, rst_n, start, op, a, b, mode -> result, rem, neg, busy, done, valid, err.
module calc_engine #(
  parameter int W  = 7,
  parameter int RW = 2*W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          mode,
  output logic [RW-1:0] result,
  output logic [W-1:0]  rem,
  output logic          neg,
  output logic          busy,
  output logic          done,
  output logic          valid,
  output logic          err
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIN
  } st_t;

  st_t           st_q, st_d;
  logic          sq_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] mc_q, mc_d;
  logic [W-1:0]  oa_q, oa_d;
  logic [W-1:0]  ob_q, ob_d;
  logic [W-1:0]  rm_q, rm_d;
  logic [RW-1:0] res_q, res_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          neg_q, neg_d;
  logic          val_q, val_d;
  logic          err_q, err_d;

  logic          go;
  logic          last;
  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  diff;
  logic [W-1:0]  qn;
  logic [RW-1:0] sum;

  assign go    = (st_q == IDLE) && mode
               && start && !sq_q;
  assign last  = (cnt_q == CW'(W - 1));
  // Restoring step: shift next dividend bit into
  // the partial remainder, subtract if it fits.
  assign trial = {rm_q, oa_q[W-1]};
  assign ge    = (trial >= {1'b0, ob_q});
  assign diff  = trial[W-1:0] - ob_q;
  assign qn    = {oa_q[W-2:0], ge};
  assign sum   = acc_q + (ob_q[0] ? mc_q : '0);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mc_d  = mc_q;
    oa_d  = oa_q;
    ob_d  = ob_q;
    rm_d  = rm_q;
    res_d = res_q;
    rem_d = rem_q;
    neg_d = neg_q;
    val_d = val_q;
    err_d = err_q;
    unique case (st_q)
      IDLE: begin
        if (go) begin
          unique case (1'b1)
            (op == 4'hA): begin
              res_d = RW'(a) + RW'(b);
              rem_d = '0;
              neg_d = 1'b0;
              val_d = 1'b1;
              err_d = 1'b0;
              st_d  = FIN;
            end
            (op == 4'hB): begin
              if (b > a) begin
                res_d = RW'(b - a);
                neg_d = 1'b1;
              end else begin
                res_d = RW'(a - b);
                neg_d = 1'b0;
              end
              rem_d = '0;
              val_d = 1'b1;
              err_d = 1'b0;
              st_d  = FIN;
            end
            (op == 4'hC): begin
              mc_d  = RW'(a);
              ob_d  = b;
              acc_d = '0;
              cnt_d = '0;
              st_d  = MUL;
            end
            (op == 4'hD): begin
              res_d = '0;
              rem_d = '0;
              neg_d = 1'b0;
              val_d = 1'b0;
              err_d = 1'b0;
            end
            (op == 4'hE): begin
              if (b == '0) begin
                res_d = '0;
                rem_d = '0;
                neg_d = 1'b0;
                val_d = 1'b1;
                err_d = 1'b1;
                st_d  = FIN;
              end else begin
                oa_d  = a;
                ob_d  = b;
                rm_d  = '0;
                cnt_d = '0;
                st_d  = DIV;
              end
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = sum;
        mc_d  = mc_q << 1;
        ob_d  = ob_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          res_d = sum;
          rem_d = '0;
          neg_d = 1'b0;
          val_d = 1'b1;
          err_d = 1'b0;
          st_d  = FIN;
        end
      end
      DIV: begin
        rm_d  = ge ? diff : trial[W-1:0];
        oa_d  = qn;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          res_d = RW'(qn);
          rem_d = ge ? diff : trial[W-1:0];
          neg_d = 1'b0;
          val_d = 1'b1;
          err_d = 1'b0;
          st_d  = FIN;
        end
      end
      FIN: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // sq_q resets high so a start already held
  // at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      sq_q  <= 1'b1;
      cnt_q <= '0;
      acc_q <= '0;
      mc_q  <= '0;
      oa_q  <= '0;
      ob_q  <= '0;
      rm_q  <= '0;
      res_q <= '0;
      rem_q <= '0;
      neg_q <= 1'b0;
      val_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      sq_q  <= start;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mc_q  <= mc_d;
      oa_q  <= oa_d;
      ob_q  <= ob_d;
      rm_q  <= rm_d;
      res_q <= res_d;
      rem_q <= rem_d;
      neg_q <= neg_d;
      val_q <= val_d;
      err_q <= err_d;
    end
  end

  assign result = res_q;
  assign rem    = rem_q;
  assign neg    = neg_q;
  assign valid  = val_q;
  assign err    = err_q;
  assign busy   = (st_q != IDLE);
  assign done   = (st_q == FIN);

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed self-checking bench for calc_engine (W=7).
// Drives on negedge, samples on negedge; cycle k = k-th edge after accept.
module tb_calc_engine;

  localparam int W  = 7;
  localparam int RW = 2*W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          mode;
  logic [RW-1:0] result;
  logic [W-1:0]  rem;
  logic          neg;
  logic          busy;
  logic          done;
  logic          valid;
  logic          err;

  int tests;
  int fails;
  bit saw;

  calc_engine #(.W(W), .RW(RW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .mode   (mode),
    .result (result),
    .rem    (rem),
    .neg    (neg),
    .busy   (busy),
    .done   (done),
    .valid  (valid),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0d exp=%0d",
             tag, obs, exp);
    end
  endtask

  // Returns sampled in cycle 1 after the accept edge.
  task automatic req(input logic [3:0] o,
                     input int x, input int y);
    @(negedge clk);
    op    = o;
    a     = W'(x);
    b     = W'(y);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 4'h0;
    a     = '0;
    b     = '0;
    mode  = 1'b1;
    #12;
    chk("rst_result", 32'(result), 0);
    chk("rst_rem",    32'(rem),    0);
    chk("rst_flags",
        {neg, busy, done, valid, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    req(4'hA, 100, 27);
    chk("add_done",  32'(done),   1);
    chk("add_res",   32'(result), 127);
    chk("add_neg",   32'(neg),    0);
    chk("add_valid", 32'(valid),  1);
    @(negedge clk);
    chk("add_done_off", {busy, done}, 0);
    chk("add_hold", 32'(result), 127);

    req(4'hB, 5, 9);
    chk("sub_res", 32'(result), 4);
    chk("sub_neg", 32'(neg),    1);
    req(4'hB, 9, 9);
    chk("sub_eq_res",  32'(result), 0);
    chk("sub_eq_neg",  32'(neg),    0);
    chk("sub_eq_done", 32'(done),   1);

    req(4'hC, 127, 127);
    chk("mul_c1_busy", 32'(busy), 1);
    chk("mul_c1_done", 32'(done), 0);
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      if (c == 2) begin
        start = 1'b1;
        op    = 4'hA;
        a     = 7'd1;
        b     = 7'd1;
      end
      if (c == 3) start = 1'b0;
      if (c < 8) begin
        chk("mul_busy", 32'(busy), 1);
        chk("mul_nodone", 32'(done), 0);
      end else if (c == 8) begin
        chk("mul_done", 32'(done), 1);
        chk("mul_res", 32'(result), 16129);
        chk("mul_neg", 32'(neg), 0);
      end else begin
        chk("mul_after", {busy, done}, 0);
      end
    end
    @(negedge clk);
    chk("mul_no_queue", {busy, done}, 0);

    req(4'hE, 100, 7);
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (c < 8) chk("div_nodone", 32'(done), 0);
    end
    chk("div_done", 32'(done),   1);
    chk("div_q",    32'(result), 14);
    chk("div_r",    32'(rem),    2);
    chk("div_err",  32'(err),    0);

    req(4'hE, 5, 0);
    chk("dz_done",  32'(done),   1);
    chk("dz_err",   32'(err),    1);
    chk("dz_res",   32'(result), 0);
    chk("dz_rem",   32'(rem),    0);
    chk("dz_valid", 32'(valid),  1);

    req(4'hA, 3, 4);
    chk("ok_clr_err", 32'(err),    0);
    chk("ok_res",     32'(result), 7);

    mode = 1'b0;
    req(4'hA, 1, 1);
    chk("mode0_idle", {busy, done}, 0);
    chk("mode0_hold", 32'(result), 7);
    mode = 1'b1;

    req(4'h3, 1, 1);
    chk("badop_idle", {busy, done}, 0);
    chk("badop_hold", 32'(result), 7);

    req(4'hD, 0, 0);
    chk("clr_done",  32'(done),   0);
    chk("clr_busy",  32'(busy),   0);
    chk("clr_res",   32'(result), 0);
    chk("clr_valid", 32'(valid),  0);
    chk("clr_err",   32'(err),    0);

    req(4'hA, 100, 27);
    chk("pre_rst_res", 32'(result), 127);
    req(4'hC, 127, 127);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    start = 1'b1;
    op    = 4'hA;
    a     = 7'd2;
    b     = 7'd3;
    #1;
    chk("mrst_res", 32'(result), 0);
    chk("mrst_flags",
        {neg, busy, done, valid, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("no_done_after_rst", 32'(saw), 0);
    chk("held_start_ign", 32'(valid), 0);
    @(negedge clk);
    start = 1'b0;

    req(4'hA, 2, 3);
    chk("post_rst_done", 32'(done),   1);
    chk("post_rst_res",  32'(result), 5);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 SHALL have parameter W, default 7, operand width in bits (legal range 2..16).
REQ-002 SHALL have parameter RW, default 2*W, result width in bits.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  level request; a request is its rising edge, detected against the previous cycle's sample.
REQ-006 SHALL have port op  input  4  keypad opcode: 4'hA add, 4'hB sub, 4'hC mul, 4'hD clear, 4'hE div.
REQ-007 SHALL have port a  input  W  operand 1, unsigned.
REQ-008 SHALL have port b  input  W  operand 2, unsigned.
REQ-009 SHALL have port mode  input  1  calculator mode enable; 0 ignores all requests.
REQ-010 SHALL have port result  output  RW  magnitude of the last result (quotient for div).
REQ-011 SHALL have port rem  output  W  remainder of the last div; 0 after any other op.
REQ-012 SHALL have port neg  output  1  result sign; 1 = negative.
REQ-013 SHALL have port busy  output  1  high while a multi-cycle op runs.
REQ-014 SHALL have port done  output  1  single-cycle completion pulse.
REQ-015 SHALL have port valid  output  1  sticky flag: result holds a completed answer.
REQ-016 SHALL have port err  output  1  sticky flag: divide by zero.

Function
REQ-017 SHALL accept a request only when the state is IDLE, mode=1, a start rising edge is detected and op is one of A..E; all other requests are dropped with no output change.
REQ-018 SHALL latch a, b and op in the accept cycle; later input changes SHALL NOT affect the operation in flight.
REQ-019 SHALL implement states IDLE, MUL, DIV and FIN with these transitions:
- IDLE->MUL on an accepted mul.
- IDLE->DIV on an accepted div with b!=0.
- IDLE->FIN on an accepted add, sub, or div with b==0.
- MUL->FIN and DIV->FIN after W iterations.
- FIN->IDLE unconditionally.
REQ-020 SHALL assert busy in MUL, DIV and FIN.
REQ-021 SHALL assert done for exactly the FIN cycle, and SHALL set valid in that same cycle.
REQ-022 For add, SHALL register result=a+b zero-extended to RW and neg=0; done SHALL follow the accept by 1 cycle.
REQ-023 For sub, SHALL produce result=|a-b|, with neg=1 iff b>a; a==b SHALL give result 0, neg 0.
REQ-024 For mul, SHALL perform a shift-add, one bit of b per cycle, LSB first; result=a*b exact in RW bits, neg=0; done SHALL follow the accept by W+1 cycles.
REQ-025 For div, SHALL perform restoring division, one quotient bit per cycle, MSB first; result=a/b zero-extended, rem=a%b, neg=0; done SHALL follow the accept by W+1 cycles.
REQ-026 Div with b==0 SHALL set err=1, result=0, rem=0, neg=0; done SHALL follow the accept by 1 cycle and valid SHALL be set.
REQ-027 Any successful non-clear op SHALL clear err at its done.
REQ-028 Clear (op D) SHALL, in the accept cycle:
- zero result, rem, neg, valid and err;
- not enter FIN, so no done pulse is produced.
REQ-029 A start edge while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-030 Deasserting mode mid-operation SHALL NOT abort the operation in flight.
REQ-031 result, rem and neg SHALL hold their value until the next done or clear.

Reset
REQ-032 rst_n=0 SHALL, asynchronously:
- force IDLE;
- set result=0, rem=0, neg=0, busy=0, done=0, valid=0, err=0;
- clear the start edge detector.
REQ-033 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-034 A start already held high at reset release SHALL NOT count as an edge.

Verification
REQ-035 W=7, a=100, b=27, op A, start edge -> 1 cycle later done=1, result=127, neg=0, valid=1.
REQ-036 a=5, b=9, op B -> result=4, neg=1; then a=9, b=9, op B -> result=0, neg=0.
REQ-037 a=127, b=127, op C -> busy for cycles 1..8; done at cycle 8, result=16129; a second start edge at cycle 3 is ignored.
REQ-038 a=100, b=7, op E -> done at cycle 8, result=14, rem=2; then b=0, op E -> done after 1 cycle, err=1, result=0.
REQ-039 Mid-multiply (cycle 4), pulse rst_n low -> all outputs 0 immediately; no done is seen afterwards.
REQ-040 After a completed add, op D -> result=0, valid=0, err=0, and done stays 0.
